// File: rtl/odd_div_pkg.sv
// Shared constants and sizing helpers for the odd-ratio, 50%-duty clock dividers.
`timescale 1ns/1ps
package odd_div_pkg;

  localparam int unsigned DIV_A_DEF = 3;
  localparam int unsigned DIV_B_DEF = 5;

  // Last counter value that still belongs to the high phase of p.
  function automatic int unsigned half_hi(input int unsigned n);
    return (n - 1) / 2;
  endfunction

  function automatic int unsigned cnt_w(input int unsigned n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/odd_clk_div.sv
// Divide-by-N (odd N) clock with exact 50% duty: posedge phase reg ANDed with its
// negedge-delayed copy, so only one AND input toggles at any clk edge.
`timescale 1ns/1ps
module odd_clk_div
  import odd_div_pkg::*;
#(
  parameter int unsigned N = DIV_A_DEF
) (
  input  logic clk,
  input  logic rst_n,
  output logic clk_out
);

  localparam int unsigned CW   = (cnt_w(N) > 0) ? cnt_w(N) : 1;
  localparam int unsigned HALF = half_hi(N);

  if (((N % 2) == 0) || (N < 3)) begin : g_bad_ratio
    $error("odd_clk_div: N must be odd and >= 3");
  end

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;
  logic          p;
  logic          p_next;
  logic          n;

  // Counter and phase register; reset to N-1 so the first posedge lands on 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= CW'(N - 1);
      p   <= 1'b0;
    end else begin
      cnt <= cnt_next;
      p   <= p_next;
    end
  end

  always_comb begin
    cnt_next = cnt + CW'(1);
    if (cnt == CW'(N - 1)) begin
      cnt_next = '0;
    end
    p_next = (cnt_next <= CW'(HALF));
  end

  // Half-cycle delayed phase trims the high time from (N+1)/2 to N/2 cycles.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n <= 1'b0;
    end else begin
      n <= p;
    end
  end

  assign clk_out = p & n;

  a_cnt_range : assert property (@(posedge clk) disable iff (!rst_n) cnt <= CW'(N - 1))
    else $error("odd_clk_div: counter out of range");

endmodule

// File: rtl/odd_freq_divider.sv
// Two independent odd-ratio 50%-duty clock dividers driven from one source clock.
`timescale 1ns/1ps
module odd_freq_divider
  import odd_div_pkg::*;
#(
  parameter int unsigned DIV_A = DIV_A_DEF,
  parameter int unsigned DIV_B = DIV_B_DEF
) (
  input  logic clk,
  input  logic rst_n,
  output logic clk_div3,
  output logic clk_div5
);

  odd_clk_div #(.N(DIV_A)) u_div_a (
    .clk     (clk),
    .rst_n   (rst_n),
    .clk_out (clk_div3)
  );

  odd_clk_div #(.N(DIV_B)) u_div_b (
    .clk     (clk),
    .rst_n   (rst_n),
    .clk_out (clk_div5)
  );

endmodule

// File: tb/tb_odd_freq_divider.sv
// Directed bench: expected edge times queued at each reset release, compared with recorded edges.
`timescale 1ns/1ps
module tb_odd_freq_divider;

  logic clk;
  logic rst_n;
  logic d3, d5, d7, d9;

  int checks = 0;
  int errors = 0;

  odd_freq_divider u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clk_div3 (d3),
    .clk_div5 (d5)
  );

  odd_freq_divider #(.DIV_A(7), .DIV_B(9)) u_dut79 (
    .clk      (clk),
    .rst_n    (rst_n),
    .clk_div3 (d7),
    .clk_div5 (d9)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  longint ar3[$], af3[$], ar5[$], af5[$], ar7[$], af7[$], ar9[$], af9[$];
  longint er3[$], ef3[$], er5[$], ef5[$], er7[$], ef7[$], er9[$], ef9[$];

  always @(posedge d3) ar3.push_back(longint'($time));
  always @(negedge d3) af3.push_back(longint'($time));
  always @(posedge d5) ar5.push_back(longint'($time));
  always @(negedge d5) af5.push_back(longint'($time));
  always @(posedge d7) ar7.push_back(longint'($time));
  always @(negedge d7) af7.push_back(longint'($time));
  always @(posedge d9) ar9.push_back(longint'($time));
  always @(negedge d9) af9.push_back(longint'($time));

  task automatic check(input string tag, input longint act, input longint exp);
    checks++;
    assert (act === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, act, exp);
    end
  endtask

  // Model: first rise half a cycle after the first posedge, period N*10, high N*5.
  task automatic build(input longint first_rise, input longint last, input longint ratio,
                       output longint r[$], output longint f[$]);
    r = {};
    f = {};
    for (longint t = first_rise; t <= last; t += ratio * 10) r.push_back(t);
    for (longint t = first_rise + ratio * 5; t <= last; t += ratio * 10) f.push_back(t);
  endtask

  task automatic cmp_q(input string tag, input longint act[$], input longint exp[$]);
    int n;
    check({tag, "_count"}, longint'(act.size()), longint'(exp.size()));
    n = (act.size() < exp.size()) ? act.size() : exp.size();
    for (int i = 0; i < n; i++) check($sformatf("%s[%0d]", tag, i), act[i], exp[i]);
  endtask

  task automatic clear_actual();
    ar3 = {}; af3 = {}; ar5 = {}; af5 = {};
    ar7 = {}; af7 = {}; ar9 = {}; af9 = {};
  endtask

  task automatic expect_all(input longint first_rise, input longint last);
    build(first_rise, last, 3, er3, ef3);
    build(first_rise, last, 5, er5, ef5);
    build(first_rise, last, 7, er7, ef7);
    build(first_rise, last, 9, er9, ef9);
  endtask

  task automatic compare_all(input string ph);
    cmp_q({ph, "_rise3"}, ar3, er3);
    cmp_q({ph, "_fall3"}, af3, ef3);
    cmp_q({ph, "_rise5"}, ar5, er5);
    cmp_q({ph, "_fall5"}, af5, ef5);
    cmp_q({ph, "_rise7"}, ar7, er7);
    cmp_q({ph, "_fall7"}, af7, ef7);
    cmp_q({ph, "_rise9"}, ar9, er9);
    cmp_q({ph, "_fall9"}, af9, ef9);
  endtask

  initial begin
    int common;
    rst_n = 1'b0;

    // Reset hold
    #12;
    check("rst_div3", longint'(d3), 0);
    check("rst_div5", longint'(d5), 0);
    check("rst_div7", longint'(d7), 0);
    check("rst_div9", longint'(d9), 0);

    // Release at 22; first posedge at 25, first rise expected at 30
    #10;
    clear_actual();
    rst_n = 1'b1;
    expect_all(30, 1002);
    #5;
    check("pre_rise_div3", longint'(d3), 0);
    check("pre_rise_div5", longint'(d5), 0);
    #5;
    check("first_hi_div3", longint'(d3), 1);
    check("first_hi_div5", longint'(d5), 1);

    #970;
    compare_all("run1");
    common = 0;
    foreach (ar3[i]) foreach (ar5[j]) if (ar3[i] == ar5[j]) common++;
    check("align_3_5", longint'(common), 7);

    // Mid-high reset: clk_div5 rose at 1030, clk_div3 high from 1020 to 1035
    #30;
    check("midhi_div3", longint'(d3), 1);
    check("midhi_div5", longint'(d5), 1);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_rst_div3", longint'(d3), 0);
    check("async_rst_div5", longint'(d5), 0);
    check("async_rst_div7", longint'(d7), 0);
    check("async_rst_div9", longint'(d9), 0);
    #16;
    check("hold_div3", longint'(d3), 0);
    check("hold_div5", longint'(d5), 0);

    // Re-release at 1062; first posedge 1065, first rise 1070
    #12;
    clear_actual();
    rst_n = 1'b1;
    expect_all(1070, 1302);
    #240;
    compare_all("run2");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
